// File: rtl/snn_pkg.sv
// Shared types and constants for the layer-2 LIF neuron bank.
// Holds the control state type, bank dimensions and the membrane clamp.
package snn_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_EMIT,
        S_DONE
    } state_t;

    localparam int N          = 25;
    localparam int MEM_W      = 12;
    localparam int THRESH     = 64;
    localparam int LEAK_SHIFT = 3;
    localparam int REFRAC     = 2;
    localparam int T_STEPS    = 16;
    localparam int CUR_W      = 8;

    localparam int IDX_W  = $clog2(N);
    localparam int STEP_W = $clog2(T_STEPS);
    localparam int RF_W   = $clog2(REFRAC + 1);

    localparam logic signed [MEM_W-1:0] THRESH_V = MEM_W'(THRESH);

    localparam logic signed [MEM_W:0] MEM_MAX =
        {2'b00, {(MEM_W-1){1'b1}}};
    localparam logic signed [MEM_W:0] MEM_MIN =
        {2'b11, {(MEM_W-1){1'b0}}};

    // Clamp a one-bit-wider intermediate into the membrane range
    // so an overflow pins at the rail instead of wrapping sign.
    function automatic logic signed [MEM_W-1:0] sat_mem(
        input logic signed [MEM_W:0] x
    );
        logic signed [MEM_W:0] y;
        y = x;
        if (x > MEM_MAX) begin
            y = MEM_MAX;
        end else if (x < MEM_MIN) begin
            y = MEM_MIN;
        end
        return y[MEM_W-1:0];
    endfunction

endpackage

// File: rtl/lif_neuron_bank_layer2_if.sv
// Current-in / spike-out handshake bundle of the neuron bank.
// The bank is the slave; the surrounding pipeline is the master.
interface lif_neuron_bank_layer2_if;
    import snn_pkg::*;

    logic                    start;
    logic signed [CUR_W-1:0] cur_in;
    logic                    cur_valid;
    logic                    cur_ready;
    logic [IDX_W-1:0]        cur_idx;
    logic [N-1:0]            spikes_out;
    logic                    spikes_valid;
    logic                    spikes_ready;
    logic [STEP_W-1:0]       step_idx;
    logic                    busy;
    logic                    done;

    modport master (
        output start, cur_in, cur_valid, spikes_ready,
        input  cur_ready, cur_idx, spikes_out, spikes_valid,
        input  step_idx, busy, done
    );

    modport slave (
        input  start, cur_in, cur_valid, spikes_ready,
        output cur_ready, cur_idx, spikes_out, spikes_valid,
        output step_idx, busy, done
    );

endinterface

// File: rtl/lif_update.sv
// Single-neuron leaky integrate-and-fire update, purely combinational.
// Shared by every neuron of the bank through the index mux.
module lif_update
    import snn_pkg::*;
(
    input  logic signed [MEM_W-1:0] v_i,
    input  logic [RF_W-1:0]         rf_i,
    input  logic signed [CUR_W-1:0] cur_i,
    output logic signed [MEM_W-1:0] v_o,
    output logic [RF_W-1:0]         rf_o,
    output logic                    spike_o
);

    logic signed [MEM_W:0]   v_x;
    logic signed [MEM_W:0]   leak;
    logic signed [MEM_W:0]   cur_x;
    logic signed [MEM_W:0]   sum;
    logic signed [MEM_W-1:0] v_sat;

    // Leak and integrate one bit wide, then clamp back to range.
    always_comb begin
        v_x   = {v_i[MEM_W-1], v_i};
        leak  = v_x >>> LEAK_SHIFT;
        cur_x = {{(MEM_W+1-CUR_W){cur_i[CUR_W-1]}}, cur_i};
        sum   = v_x - leak + cur_x;
        v_sat = sat_mem(sum);
    end

    // Refractory neurons discard the current; others fire at threshold.
    always_comb begin
        v_o     = v_sat;
        rf_o    = rf_i;
        spike_o = 1'b0;
        if (rf_i != '0) begin
            v_o  = '0;
            rf_o = rf_i - RF_W'(1);
        end else if (v_sat >= THRESH_V) begin
            v_o     = '0;
            rf_o    = RF_W'(REFRAC);
            spike_o = 1'b1;
        end
    end

endmodule

// File: rtl/lif_neuron_bank_layer2.sv
// Time-multiplexed LIF neuron bank: one current per cycle in,
// one spike vector per timestep out, T_STEPS timesteps per run.
module lif_neuron_bank_layer2
    import snn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    lif_neuron_bank_layer2_if.slave bus
);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic [N-1:0]            spk_q, spk_d;
    logic signed [MEM_W-1:0] mem_q [N];
    logic [RF_W-1:0]         rf_q [N];

    logic                    clr;
    logic                    wr;
    logic signed [MEM_W-1:0] v_nx;
    logic [RF_W-1:0]         rf_nx;
    logic                    spk_nx;

    lif_update u_upd (
        .v_i     (mem_q[idx_q]),
        .rf_i    (rf_q[idx_q]),
        .cur_i   (bus.cur_in),
        .v_o     (v_nx),
        .rf_o    (rf_nx),
        .spike_o (spk_nx)
    );

    // Control state and per-timestep bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            step_q  <= '0;
            spk_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            spk_q   <= spk_d;
        end
    end

    // Next state, neuron walk and spike vector assembly.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        step_d  = step_q;
        spk_d   = spk_q;
        clr     = 1'b0;
        wr      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    clr     = 1'b1;
                    idx_d   = '0;
                    step_d  = '0;
                    spk_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.cur_valid) begin
                    wr           = 1'b1;
                    spk_d[idx_q] = spk_nx;
                    if (idx_q == IDX_W'(N - 1)) begin
                        idx_d   = '0;
                        state_d = S_EMIT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_EMIT: begin
                if (bus.spikes_ready) begin
                    if (step_q == STEP_W'(T_STEPS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        step_d  = step_q + STEP_W'(1);
                        idx_d   = '0;
                        spk_d   = '0;
                        state_d = S_ACCUM;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Membrane and refractory array; cleared wholesale on start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
                rf_q[i]  <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
                rf_q[i]  <= '0;
            end
        end else if (wr) begin
            mem_q[idx_q] <= v_nx;
            rf_q[idx_q]  <= rf_nx;
        end
    end

    assign bus.cur_ready    = (state_q == S_ACCUM);
    assign bus.spikes_valid = (state_q == S_EMIT);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.cur_idx      = idx_q;
    assign bus.step_idx     = step_q;
    assign bus.spikes_out   = spk_q;

endmodule

// File: tb/tb_lif_neuron_bank_layer2.sv
// Self-checking bench for the layer-2 LIF neuron bank.
// A plain-arithmetic neuron model runs alongside the DUT.
module tb_lif_neuron_bank_layer2;
    import snn_pkg::*;

    localparam int P_IDLE = 0;
    localparam int P_ACC  = 1;
    localparam int P_EMIT = 2;
    localparam int P_DONE = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    lif_neuron_bank_layer2_if ifc ();

    lif_neuron_bank_layer2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int           ph;
    int           midx;
    int           mstep;
    int           mv [N];
    int           mrf [N];
    logic [N-1:0] mspk;
    int           v0_hist [T_STEPS];
    int           v5_last;

    logic [N-1:0] vecs [$];
    int           done_cnt;
    int           stall_seen;
    bit           hold_pend;
    logic [N-1:0] hold_vec;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int fdiv8(input int v);
        return (v >= 0) ? v / 8 : -((-v + 7) / 8);
    endfunction

    task automatic mreset();
        ph    = P_IDLE;
        midx  = 0;
        mstep = 0;
        mspk  = '0;
        for (int i = 0; i < N; i++) begin
            mv[i]  = 0;
            mrf[i] = 0;
        end
    endtask

    task automatic model_edge();
        int c;
        int nv;
        bit s;
        case (ph)
            P_IDLE: begin
                if (ifc.start) begin
                    mreset();
                    ph = P_ACC;
                end
            end
            P_ACC: begin
                if (ifc.cur_valid) begin
                    c = int'(ifc.cur_in);
                    s = 1'b0;
                    if (mrf[midx] > 0) begin
                        mv[midx]  = 0;
                        mrf[midx] = mrf[midx] - 1;
                    end else begin
                        nv = mv[midx] - fdiv8(mv[midx]) + c;
                        if (nv > 2047) nv = 2047;
                        if (nv < -2048) nv = -2048;
                        if (nv >= 64) begin
                            s         = 1'b1;
                            mv[midx]  = 0;
                            mrf[midx] = 2;
                        end else begin
                            mv[midx] = nv;
                        end
                    end
                    mspk[midx] = s;
                    midx++;
                    if (midx == N) begin
                        midx = 0;
                        ph   = P_EMIT;
                    end
                end
            end
            P_EMIT: begin
                if (ifc.spikes_ready) begin
                    v0_hist[mstep] = mv[0];
                    v5_last        = mv[5];
                    if (mstep == T_STEPS - 1) begin
                        ph = P_DONE;
                    end else begin
                        mstep++;
                        mspk = '0;
                        ph   = P_ACC;
                    end
                end
            end
            default: ph = P_IDLE;
        endcase
    endtask

    // Reference model advances on every clock edge or async reset.
    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) mreset();
            else model_edge();
        end
    end

    // Compare DUT against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("cur_ready", ifc.cur_ready, ph == P_ACC);
                check("spikes_valid", ifc.spikes_valid, ph == P_EMIT);
                check("busy", ifc.busy, ph != P_IDLE);
                check("done", ifc.done, ph == P_DONE);
                if (ph != P_IDLE) check("step_idx", ifc.step_idx, mstep);
                if (ph == P_ACC) check("cur_idx", ifc.cur_idx, midx);
                if (ph == P_EMIT) check("spikes_out", ifc.spikes_out, mspk);
                if (hold_pend) begin
                    check("hold_valid", ifc.spikes_valid, 1);
                    check("hold_vec", ifc.spikes_out, hold_vec);
                end
                hold_pend = ifc.spikes_valid && !ifc.spikes_ready;
                hold_vec  = ifc.spikes_out;
                if (hold_pend) stall_seen++;
                if (ifc.spikes_valid && ifc.spikes_ready)
                    vecs.push_back(ifc.spikes_out);
                if (ifc.done) done_cnt++;
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [7:0] cur_for(input int md,
                                                  input int idx);
        case (md)
            0: return (idx == 0) ? 8'sd20 : 8'sd0;
            1: return 8'sd64;
            2: return (idx == 5) ? -8'sd128 : 8'sd0;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic run(input int md, input bit gaps, input int stall_step);
        int stalls;
        int guard;
        stalls     = 0;
        guard      = 0;
        stall_seen = 0;
        done_cnt   = 0;
        vecs.delete();
        ifc.start = 1'b1;
        cyc();
        ifc.start = 1'b0;
        do begin
            ifc.cur_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            ifc.cur_in    = cur_for(md, midx);
            ifc.start     = gaps ? ($urandom_range(0, 9) == 0) : 1'b0;
            if (ph == P_EMIT && mstep == stall_step && stalls < 7) begin
                ifc.spikes_ready = 1'b0;
                ifc.cur_valid    = 1'($urandom_range(0, 1));
                stalls++;
            end else begin
                ifc.spikes_ready = 1'b1;
            end
            cyc();
            guard++;
        end while (ph != P_IDLE && guard < 3000);
        ifc.start     = 1'b0;
        ifc.cur_valid = 1'b0;
        check("run_in_budget", guard < 3000, 1);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_cur_ready"}, ifc.cur_ready, 0);
        check({tag, "_spikes_valid"}, ifc.spikes_valid, 0);
        check({tag, "_busy"}, ifc.busy, 0);
        check({tag, "_done"}, ifc.done, 0);
        check({tag, "_spikes_out"}, ifc.spikes_out, 0);
        check({tag, "_cur_idx"}, ifc.cur_idx, 0);
        check({tag, "_step_idx"}, ifc.step_idx, 0);
    endtask

    logic [31:0] expv;
    logic [31:0] actv;

    initial begin
        ifc.start        = 1'b0;
        ifc.cur_in       = '0;
        ifc.cur_valid    = 1'b0;
        ifc.spikes_ready = 1'b0;
        hold_pend        = 1'b0;
        repeat (3) cyc();
        check_idle_zero("por");
        rst_n = 1'b1;
        cyc();

        // Reset mid-ACCUM after ten currents.
        ifc.start = 1'b1;
        cyc();
        ifc.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ifc.cur_valid = 1'b1;
            ifc.cur_in    = 8'sd50;
            cyc();
        end
        check("pre_rst_cur_idx", ifc.cur_idx, 10);
        rst_n = 1'b0;
        #1;
        check_idle_zero("midrst");
        ifc.cur_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();

        // Neuron 0 driven with 20 every step.
        run(0, 1'b0, -1);
        check("n0_vec_count", vecs.size(), T_STEPS);
        check("n0_done_pulses", done_cnt, 1);
        for (int s = 0; s < T_STEPS; s++) begin
            expv = (s % 6 == 3) ? 32'd1 : 32'd0;
            actv = (s < vecs.size()) ? 32'(vecs[s]) : 32'hxxxxxxxx;
            check($sformatf("n0_vec%0d", s), actv, expv);
        end
        check("n0_v_step0", v0_hist[0], 20);
        check("n0_v_step1", v0_hist[1], 38);
        check("n0_v_step2", v0_hist[2], 54);
        check("n0_v_step6", v0_hist[6], 20);

        // All neurons at 64, with a 7-cycle back-pressure stall.
        run(1, 1'b0, 1);
        check("all_vec_count", vecs.size(), T_STEPS);
        check("all_stall_cycles", stall_seen, 7);
        for (int s = 0; s < T_STEPS; s++) begin
            expv = (s % 3 == 0) ? 32'h01FF_FFFF : 32'd0;
            actv = (s < vecs.size()) ? 32'(vecs[s]) : 32'hxxxxxxxx;
            check($sformatf("all_vec%0d", s), actv, expv);
        end

        // Neuron 5 pulled negative: no spikes, no wrap.
        run(2, 1'b0, -1);
        check("neg_vec_count", vecs.size(), T_STEPS);
        for (int s = 0; s < T_STEPS; s++) begin
            actv = (s < vecs.size()) ? 32'(vecs[s]) : 32'hxxxxxxxx;
            check($sformatf("neg_vec%0d", s), actv, 0);
        end
        check("neg_v5_range", (v5_last <= -800) && (v5_last >= -1024), 1);

        // Random currents, valid gaps and stray start pulses.
        run(3, 1'b1, -1);
        check("rand_vec_count", vecs.size(), T_STEPS);
        check("rand_done_pulses", done_cnt, 1);

        cyc();
        check("final_busy", ifc.busy, 0);
        check("final_cur_ready", ifc.cur_ready, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lif_neuron_bank_layer2.md
# lif_neuron_bank_layer2

Time-multiplexed bank of leaky integrate-and-fire neurons that converts signed 8-bit layer-2 neuron currents (MAC + bias results) into a per-timestep spike vector. It is the spike-producing end of the layer interface: its `spikes_out` vector is exactly the `pixels` spike vector consumed by the next MAC stage. One neuron current is accepted per cycle, membrane state is held in an internal register array, and a full N-bit spike vector is emitted once per timestep for `T_STEPS` timesteps per inference run.

## Interface
- `N`, 25, neurons in the bank; also the spike vector width.
- `MEM_W`, 12, signed membrane potential width.
- `THRESH`, 64, firing threshold (signed, compared at `MEM_W` bits).
- `LEAK_SHIFT`, 3, leak = arithmetic right shift of membrane by this amount.
- `REFRAC`, 2, refractory length in timesteps after a spike.
- `T_STEPS`, 16, timesteps per inference run.

- `clk` input 1 single clock, rising edge.
- `rst_n` input 1 asynchronous active-low reset.
- `start` input 1 begin an inference run; honoured only in IDLE.
- `cur_in` input 8 signed current for neuron `cur_idx`.
- `cur_valid` input 1 `cur_in` valid.
- `cur_ready` output 1 bank accepts a current this cycle.
- `cur_idx` output $clog2(N) index of neuron the next accepted current belongs to.
- `spikes_out` output N spike vector for the current timestep, bit i = neuron i.
- `spikes_valid` output 1 `spikes_out` valid; held until accepted.
- `spikes_ready` input 1 downstream accepts the spike vector.
- `step_idx` output $clog2(T_STEPS) current timestep.
- `busy` output 1 high in any state except IDLE.
- `done` output 1 one-cycle pulse after the last timestep's vector is accepted.

## Operation
- States: IDLE, ACCUM, EMIT, DONE.
- IDLE: `start`=1 -> clear all membranes and refractory counters, `step_idx`=0, `cur_idx`=0, `spikes_out`=0, go ACCUM.
- ACCUM: `cur_ready`=1. Accept when `cur_valid && cur_ready`. For neuron i=`cur_idx`:
  - if `refrac[i]` != 0: v[i] <= 0, `refrac[i]` decrements, spike bit i = 0 (current consumed, discarded).
  - else v_next = v - (v >>> LEAK_SHIFT) + sext(cur_in), computed at MEM_W+1 bits, saturated to signed MEM_W range.
  - if v_next >= THRESH: spike bit i = 1, v[i] <= 0, `refrac[i]` <= REFRAC; else v[i] <= v_next.
  - `cur_idx` increments; after accepting index N-1 go EMIT.
- EMIT: `spikes_valid`=1, `spikes_out` stable. On `spikes_valid && spikes_ready`: if `step_idx`=T_STEPS-1 go DONE, else `step_idx`+1, `cur_idx`=0, clear `spikes_out`, go ACCUM.
- DONE: `done`=1 for one cycle, go IDLE. Membranes retained until next `start`.
- `start` outside IDLE is ignored.

## Timing
- Reset (async, any state, mid-run included): state IDLE; `cur_ready`, `spikes_valid`, `busy`, `done`, `spikes_out`, `cur_idx`, `step_idx` all 0; membranes and refractory counters 0.
- `start` sampled in IDLE -> `cur_ready`=1 next cycle.
- Throughput: one current per cycle; minimum N cycles ACCUM + 1 cycle EMIT per timestep.
- Accepting current N-1 at edge k -> `spikes_valid`=1 from cycle k+1; `cur_ready`=0 while in EMIT.
- `spikes_valid` never drops without a transfer; `spikes_out` does not change while valid.
- Vector accepted at edge m -> `cur_ready`=1 at m+1 (or `done`=1 at m+1 on last step).
- `cur_valid` gaps stall ACCUM with no state change.

## Structure
- Shared package `snn_pkg`: state enum type, default constants (N, MEM_W, THRESH, LEAK_SHIFT, REFRAC, T_STEPS), saturation helper function.
- One combinational sub-module `lif_update`: inputs v, refractory count, current; outputs next v, next refractory, spike bit. Bank instantiates one and muxes the membrane array by `cur_idx`.

## Test plan
- Reset mid-ACCUM (after 10 currents) -> all outputs 0 immediately, state IDLE, next `start` begins at `step_idx`=0 with zeroed membranes.
- Neuron 0 fed 20 every step, others 0 -> v: 20, 38, 54, spike at step 3 (v_next 68), `spikes_out`=0x0000001 only at step 3; no spike steps 4-5 (refractory); v=20 again at step 6.
- All neurons fed 64 -> every neuron spikes steps 0, 3, 6, 9, 12, 15 (`spikes_out`=0x1FFFFFF), all-zero otherwise.
- Neuron 5 fed -128 every step -> v converges to -1024, never spikes, no saturation wrap; `spikes_out` bit 5 always 0.
- `spikes_ready` held low 7 cycles in EMIT -> `spikes_valid` and `spikes_out` stable 7 cycles, `cur_ready`=0; `cur_valid` pulses ignored.
- Full run with randomized `cur_valid` gaps -> exactly 16 vectors transferred, `done` single pulse after 16th, `start` pulses during run ignored.
